// File: rtl/imm_pkg.sv
// Immediate-format selector encoding and the shared extraction function.
package imm_pkg;

  typedef enum logic [2:0] {
    I_TYPE  = 3'd0,
    S_TYPE  = 3'd1,
    B_TYPE  = 3'd2,
    U_TYPE  = 3'd3,
    J_TYPE  = 3'd4,
    Z_TYPE  = 3'd5,
    SH_TYPE = 3'd6,
    INV     = 3'd7
  } imm_type_t;

  localparam int IMM_ERRCNT_W = 16;

  // Result is always 64 bits; callers truncate to XLEN. SH returns the 6-bit
  // shamt, and 32-bit callers clear bit 5 themselves.
  function automatic logic [63:0] imm_extract(input logic [31:0] instr,
                                              input imm_type_t   sel);
    logic [63:0] r;
    r = '0;
    unique case (sel)
      I_TYPE:  r = {{52{instr[31]}}, instr[31:20]};
      S_TYPE:  r = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      B_TYPE:  r = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      U_TYPE:  r = {{32{instr[31]}}, instr[31:12], 12'b0};
      J_TYPE:  r = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      Z_TYPE:  r = {59'b0, instr[19:15]};
      SH_TYPE: r = {58'b0, instr[25:20]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_pipe_slice.sv
// One elastic register slice: accepts when empty or when draining this cycle.
module imm_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extract/extend at the input, then STAGES
// elastic slices. IMMGEN_ERRCNT_EN enables the saturating invalid-selector count.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAGW   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [2:0]              in_immsrc,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_imm,
  output logic [TAGW-1:0]         out_tag,
  output logic                    out_err,
  output logic [IMM_ERRCNT_W-1:0] err_count
);

  localparam int PW = XLEN + TAGW + 1;

  if (!(XLEN == 32 || XLEN == 64) || STAGES < 1 || STAGES > 4) begin : g_bad_cfg
    $fatal(1, "imm_gen_pipe: illegal XLEN=%0d or STAGES=%0d", XLEN, STAGES);
  end

  imm_type_t       sel;
  logic [XLEN-1:0] ext_imm;
  logic            ext_err;

  assign sel = imm_type_t'(in_immsrc);

  always_comb begin
    ext_imm = XLEN'(imm_extract(in_instr, sel));
    // RV32 shamt is only 5 bits wide
    if (XLEN == 32 && sel == SH_TYPE) ext_imm[5] = 1'b0;
    ext_err = (sel == INV);
  end

  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0]         rdy_pipe;
  logic [STAGES:0][PW-1:0] dat_pipe;

  assign vld_pipe[0]      = in_valid;
  assign dat_pipe[0]      = {ext_err, in_tag, ext_imm};
  assign rdy_pipe[STAGES] = out_ready;
  assign in_ready         = rdy_pipe[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    imm_pipe_slice #(.W(PW)) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (vld_pipe[k]),
      .in_ready (rdy_pipe[k]),
      .in_data  (dat_pipe[k]),
      .out_valid(vld_pipe[k+1]),
      .out_ready(rdy_pipe[k+1]),
      .out_data (dat_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign {out_err, out_tag, out_imm} = dat_pipe[STAGES];

`ifdef IMMGEN_ERRCNT_EN
  logic [IMM_ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && in_ready && ext_err && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
